// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage: zero register, same-cycle
// write-to-read bypass, and a per-register busy scoreboard for RAW detection.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
    output logic [NUM_RD*DATA_W-1:0]   RdData,
    output logic [NUM_RD-1:0]          RdBusy,
    input  logic [NUM_WR-1:0]          WrEn,
    input  logic [NUM_WR*ADDR_W-1:0]   WrAddr,
    input  logic [NUM_WR*DATA_W-1:0]   WrData,
    input  logic                       RsvEn,
    input  logic [ADDR_W-1:0]          RsvAddr,
    output logic [NUM_REGS-1:0]        BusyVec
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [NUM_REGS-1:0]             wr_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0] wr_val;

    // Per-register write decode; ascending port scan lets the highest port win.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                if (r != 0 && WrEn[p] && WrAddr[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = WrData[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // A new reservation outranks a completing write to the same register.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = busy_q[r];
            if (wr_hit[r])
                busy_d[r] = 1'b0;
            if (RsvEn && RsvAddr == ADDR_W'(r))
                busy_d[r] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++)
                if (wr_hit[r])
                    regs_q[r] <= wr_val[r];
            regs_q[0] <= '0;
            busy_q    <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = RdAddr[k*ADDR_W +: ADDR_W];
        assign RdData[k*DATA_W +: DATA_W] = (RESET || ra == '0) ? '0 :
                                            wr_hit[ra] ? wr_val[ra] : regs_q[ra];
        assign RdBusy[k] = ~RESET & busy_q[ra] & ~wr_hit[ra];
    end

    assign BusyVec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: array model checked every cycle plus literal
// checks; a second instance covers a 16x64, 4-read/1-write configuration.
module tb_regfile_mp;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [14:0] RdAddr;
    logic [95:0] RdData;
    logic [2:0]  RdBusy;
    logic [1:0]  WrEn;
    logic [9:0]  WrAddr;
    logic [63:0] WrData;
    logic        RsvEn;
    logic [4:0]  RsvAddr;
    logic [31:0] BusyVec;

    logic [15:0]  RdAddr2;
    logic [255:0] RdData2;
    logic [3:0]   RdBusy2;
    logic [0:0]   WrEn2;
    logic [3:0]   WrAddr2;
    logic [63:0]  WrData2;
    logic         RsvEn2;
    logic [3:0]   RsvAddr2;
    logic [15:0]  BusyVec2;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [32];
    bit          bsy [32];

    always #5 CLK = ~CLK;

    regfile_mp dut (
        .CLK(CLK), .RESET(RESET), .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .RsvEn(RsvEn),
        .RsvAddr(RsvAddr), .BusyVec(BusyVec)
    );

    regfile_mp #(.DATA_W(64), .NUM_REGS(16), .ADDR_W(4), .NUM_RD(4), .NUM_WR(1)) dut2 (
        .CLK(CLK), .RESET(RESET), .RdAddr(RdAddr2), .RdData(RdData2), .RdBusy(RdBusy2),
        .WrEn(WrEn2), .WrAddr(WrAddr2), .WrData(WrData2), .RsvEn(RsvEn2),
        .RsvAddr(RsvAddr2), .BusyVec(BusyVec2)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: which value would a reader of register a see right now?
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (RESET || a == 0) return 32'h0;
        for (int p = 1; p >= 0; p--)
            if (WrEn[p] && WrAddr[p*5 +: 5] == a) return WrData[p*32 +: 32];
        return mem[a];
    endfunction

    function automatic bit exp_busy(input logic [4:0] a);
        if (RESET || a == 0) return 1'b0;
        for (int p = 0; p < 2; p++)
            if (WrEn[p] && WrAddr[p*5 +: 5] == a) return 1'b0;
        return bsy[a];
    endfunction

    function automatic logic [31:0] exp_bv();
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = bsy[r];
        return RESET ? 32'h0 : v;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int r = 0; r < 32; r++) begin mem[r] = '0; bsy[r] = 1'b0; end
        end else begin
            for (int p = 0; p < 2; p++)
                if (WrEn[p] && WrAddr[p*5 +: 5] != 0) begin
                    mem[WrAddr[p*5 +: 5]] = WrData[p*32 +: 32];
                    bsy[WrAddr[p*5 +: 5]] = 1'b0;
                end
            if (RsvEn && RsvAddr != 0) bsy[RsvAddr] = 1'b1;
        end
    end

    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_rddata%0d", k), {32'h0, RdData[k*32 +: 32]}, {32'h0, exp_rd(RdAddr[k*5 +: 5])});
            chk($sformatf("model_rdbusy%0d", k), {63'h0, RdBusy[k]}, {63'h0, exp_busy(RdAddr[k*5 +: 5])});
        end
        chk("model_busyvec", {32'h0, BusyVec}, {32'h0, exp_bv()});
    end

    task automatic clr();
        WrEn = '0; WrAddr = '0; WrData = '0; RsvEn = 0; RsvAddr = '0; RdAddr = '0;
        WrEn2 = '0; WrAddr2 = '0; WrData2 = '0; RsvEn2 = 0; RsvAddr2 = '0; RdAddr2 = '0;
    endtask

    task automatic nxt();
        @(posedge CLK); #1; clr();
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        WrEn[p] = 1'b1; WrAddr[p*5 +: 5] = a; WrData[p*32 +: 32] = d;
    endtask

    task automatic rd(input int k, input logic [4:0] a);
        RdAddr[k*5 +: 5] = a;
    endtask

    task automatic rsv(input logic [4:0] a);
        RsvEn = 1'b1; RsvAddr = a;
    endtask

    initial begin
        clr();
        RESET = 1'b1;
        #2;
        chk("reset_busyvec", {32'h0, BusyVec}, 64'h0);
        chk("reset_rddata", {32'h0, RdData[31:0]}, 64'h0);
        @(posedge CLK); #1; RESET = 1'b0;

        // Reset clears stored data and scoreboard immediately, even mid-write
        nxt(); wr(0, 5, 32'hDEADBEEF); rsv(4);
        nxt(); rd(0, 5); #2;
        chk("r5_stored", {32'h0, RdData[31:0]}, 64'hDEADBEEF);
        chk("r4_reserved", {32'h0, BusyVec}, 64'h10);
        wr(1, 5, 32'h1234); RESET = 1'b1; #1;
        chk("reset_mid_r5", {32'h0, RdData[31:0]}, 64'h0);
        chk("reset_mid_busyvec", {32'h0, BusyVec}, 64'h0);
        chk("reset_mid_rdbusy", {61'h0, RdBusy}, 64'h0);
        nxt(); RESET = 1'b0;
        nxt(); rd(0, 5); #2;
        chk("r5_after_reset", {32'h0, RdData[31:0]}, 64'h0);

        // Zero register ignores writes and reservations
        nxt(); wr(0, 0, 32'h12345678); rsv(0); rd(0, 0); rd(1, 0); #2;
        chk("r0_bypass", {32'h0, RdData[31:0]}, 64'h0);
        nxt(); rd(0, 0); #2;
        chk("r0_stored", {32'h0, RdData[31:0]}, 64'h0);
        chk("r0_busy", {63'h0, BusyVec[0]}, 64'h0);

        // Write priority and bypass
        nxt(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd(2, 7); #2;
        chk("r7_bypass_prio", {32'h0, RdData[95:64]}, 64'h22);
        nxt(); rd(2, 7); #2;
        chk("r7_stored", {32'h0, RdData[95:64]}, 64'h22);

        // Scoreboard lifecycle
        nxt(); rsv(9); rd(0, 9); #2;
        chk("r9_rsv_same_cycle", {63'h0, RdBusy[0]}, 64'h0);
        nxt(); rd(0, 9); #2;
        chk("r9_busy", {63'h0, RdBusy[0]}, 64'h1);
        chk("r9_busyvec", {63'h0, BusyVec[9]}, 64'h1);
        nxt(); wr(0, 9, 32'hAB); rd(0, 9); #2;
        chk("r9_complete_busy", {63'h0, RdBusy[0]}, 64'h0);
        chk("r9_complete_data", {32'h0, RdData[31:0]}, 64'hAB);
        nxt(); rd(0, 9); #2;
        chk("r9_cleared", {63'h0, BusyVec[9]}, 64'h0);
        chk("r9_stored", {32'h0, RdData[31:0]}, 64'hAB);

        // Reservation beats completion on the same register
        nxt(); rsv(3);
        nxt(); wr(1, 3, 32'h5); rsv(3);
        nxt(); rd(1, 3); #2;
        chk("r3_still_busy", {63'h0, BusyVec[3]}, 64'h1);
        chk("r3_data", {32'h0, RdData[63:32]}, 64'h5);
        chk("r3_rdbusy", {63'h0, RdBusy[1]}, 64'h1);

        // Mixed traffic, checked by the model each cycle
        repeat (60) begin
            nxt();
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 1) == 1) wr(p, 5'($urandom_range(0, 31)), $urandom);
            if ($urandom_range(0, 2) == 0) wr(1, WrAddr[4:0], $urandom);
            if ($urandom_range(0, 1) == 1) rsv(5'($urandom_range(0, 31)));
            for (int k = 0; k < 3; k++) rd(k, 5'($urandom_range(0, 31)));
        end

        // 16 x 64, four read ports, one write port
        nxt(); WrEn2 = 1'b1; WrAddr2 = 4'd15; WrData2 = 64'hFFFF_FFFF_0000_0001; RdAddr2 = {4{4'd15}}; #2;
        for (int k = 0; k < 4; k++)
            chk($sformatf("sweep_bypass%0d", k), RdData2[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);
        nxt(); RdAddr2 = {4{4'd15}}; #2;
        for (int k = 0; k < 4; k++)
            chk($sformatf("sweep_stored%0d", k), RdData2[k*64 +: 64], 64'hFFFF_FFFF_0000_0001);
        chk("sweep_busyvec", {48'h0, BusyVec2}, 64'h0);

        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
